// File: rtl/tcb_lib_register_response_pkg.sv
// Shared types for the TCB response register stage: response status, PHY
// parameter bundle and helpers for deriving the upstream-visible delay.
package tcb_lib_register_response_pkg;

  typedef struct packed {
    logic err;
  } tcb_rsp_sts_def_t;

  typedef struct packed {
    int unsigned abw;
    int unsigned dbw;
    int unsigned dly;
  } tcb_par_phy_t;

  localparam tcb_par_phy_t TCB_PAR_PHY_DEF = '{abw: 32, dbw: 32, dly: 1};

  // A register stage adds one cycle; upstream managers must use this delay.
  function automatic int unsigned tcb_dly_registered(input int unsigned dly);
    return dly + 1;
  endfunction

  function automatic tcb_par_phy_t tcb_phy_registered(input tcb_par_phy_t phy);
    tcb_par_phy_t r;
    r     = phy;
    r.dly = tcb_dly_registered(phy.dly);
    return r;
  endfunction

endpackage

// File: rtl/tcb_lib_register_response_if.sv
// TCB bus bundle. Handshake: a transfer happens in every cycle where vld and rdy
// are both high; rdt/sts belong to that transfer a fixed DLY cycles later.
interface tcb_lib_register_response_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32
);
  import tcb_lib_register_response_pkg::*;

  localparam int unsigned BEW = DBW / 8;

  logic             vld;
  logic             rdy;
  logic             wen;
  logic [ABW-1:0]   adr;
  logic [BEW-1:0]   ben;
  logic [DBW-1:0]   wdt;
  logic [DBW-1:0]   rdt;
  tcb_rsp_sts_def_t sts;

  modport master (output vld, wen, adr, ben, wdt, input  rdy, rdt, sts);
  modport slave  (input  vld, wen, adr, ben, wdt, output rdy, rdt, sts);

endinterface

// File: rtl/tcb_lib_register_response_tracker.sv
// Tracks transfers through a fixed-delay response path so the tail flags mark
// the cycle in which the corresponding response is present.
module tcb_lib_register_response_tracker #(
  parameter int unsigned DLY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trn_i,
  input  logic wen_i,
  output logic rsp_vld_o,
  output logic rsp_ren_o
);

  if (DLY == 0) begin : g_comb
    assign rsp_vld_o = trn_i;
    assign rsp_ren_o = trn_i & ~wen_i;
  end else begin : g_shift
    logic [DLY-1:0] trn_q, trn_d;
    logic [DLY-1:0] ren_q, ren_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        trn_q <= '0;
        ren_q <= '0;
      end else begin
        trn_q <= trn_d;
        ren_q <= ren_d;
      end
    end

    always_comb begin
      trn_d    = '0;
      ren_d    = '0;
      trn_d[0] = trn_i;
      ren_d[0] = trn_i & ~wen_i;
      for (int i = 1; i < DLY; i++) begin
        trn_d[i] = trn_q[i-1];
        ren_d[i] = ren_q[i-1];
      end
    end

    assign rsp_vld_o = trn_q[DLY-1];
    assign rsp_ren_o = ren_q[DLY-1];
  end

endmodule

// File: rtl/tcb_lib_register_response.sv
// TCB response-path register: request passes through combinationally, the
// response is registered once, so upstream sees a delay of DLY+1.
module tcb_lib_register_response
  import tcb_lib_register_response_pkg::*;
#(
  parameter int unsigned ABW  = 32,
  parameter int unsigned DBW  = 32,
  parameter int unsigned DLY  = 1,
  parameter bit          HOLD = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  tcb_lib_register_response_if.slave    sub_if,
  tcb_lib_register_response_if.master   man_if
);

  logic [ABW-1:0]   adr;
  logic [DBW-1:0]   wdt;
  logic             trn;
  logic             rsp_vld;
  logic             rsp_ren;
  logic [DBW-1:0]   rdt_q, rdt_d;
  tcb_rsp_sts_def_t sts_q, sts_d;

  assign adr        = sub_if.adr;
  assign wdt        = sub_if.wdt;
  assign man_if.vld = sub_if.vld;
  assign man_if.wen = sub_if.wen;
  assign man_if.adr = adr;
  assign man_if.ben = sub_if.ben;
  assign man_if.wdt = wdt;
  assign sub_if.rdy = man_if.rdy;

  assign trn = sub_if.vld & man_if.rdy;

  tcb_lib_register_response_tracker #(.DLY(DLY)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .trn_i     (trn),
    .wen_i     (sub_if.wen),
    .rsp_vld_o (rsp_vld),
    .rsp_ren_o (rsp_ren)
  );

  // Under HOLD, rdt only samples on read responses so undriven man_rdt never leaks.
  always_comb begin
    rdt_d = rdt_q;
    sts_d = sts_q;
    if (!HOLD) begin
      rdt_d = man_if.rdt;
      sts_d = man_if.sts;
    end else begin
      if (rsp_vld) sts_d = man_if.sts;
      if (rsp_ren) rdt_d = man_if.rdt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdt_q <= '0;
      sts_q <= '0;
    end else begin
      rdt_q <= rdt_d;
      sts_q <= sts_d;
    end
  end

  assign sub_if.rdt = rdt_q;
  assign sub_if.sts = sts_q;

endmodule
